// File: rtl/axil_cfg_slave.sv
// AXI-Lite config register slave (AW/W/AR/R only, no B channel): ID, CTRL, gated cycle counter,
// counter clear pulse and twelve scratch words.
module axil_cfg_slave #(
  parameter int unsigned ADDR_W   = 32,
  parameter logic [31:0] ID_VALUE = 32'hA11C_0001
) (
  input  logic              axis_clk,
  input  logic              axis_rst_n,
  input  logic              s_awvalid,
  input  logic [ADDR_W-1:0] s_awaddr,
  output logic              s_awready,
  input  logic              s_wvalid,
  input  logic [31:0]       s_wdata,
  input  logic [3:0]        s_wstrb,
  output logic              s_wready,
  input  logic              s_arvalid,
  input  logic [ADDR_W-1:0] s_araddr,
  output logic              s_arready,
  output logic              s_rvalid,
  output logic [31:0]       s_rdata,
  input  logic              s_rready,
  output logic [31:0]       ctrl_out
);

  localparam int unsigned NumScratch = 12;

  typedef enum logic {StIdle, StResp} rd_state_e;

  logic        aw_held_q, aw_map_q;
  logic [3:0]  aw_idx_q;
  logic        w_held_q;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;
  logic [31:0] ctrl_q, counter_q;
  logic [31:0] scratch_q [NumScratch];
  rd_state_e   rd_state_q, rd_state_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] rd_word;
  logic        aw_fire, w_fire, commit, wr_hit_ctrl, cnt_clr;
  logic [3:0]  rd_idx;
  logic        unused_addr_lsbs;

  // Byte lanes are word-granular; the low address bits carry no information.
  assign unused_addr_lsbs = ^{s_awaddr[1:0], s_araddr[1:0]};

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] strb);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
    end
    return res;
  endfunction

  assign s_awready   = !aw_held_q;
  assign s_wready    = !w_held_q;
  assign aw_fire     = s_awvalid && s_awready;
  assign w_fire      = s_wvalid && s_wready;
  assign commit      = aw_held_q && w_held_q;
  assign wr_hit_ctrl = commit && aw_map_q && (aw_idx_q == 4'd1);
  assign cnt_clr     = commit && aw_map_q && (aw_idx_q == 4'd3) && w_strb_q[0] && w_data_q[0];
  assign ctrl_out    = ctrl_q;
  assign s_rdata     = rdata_q;

  // Readies are low while held, so a new beat can never coincide with a commit.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      aw_held_q <= 1'b0;
      aw_map_q  <= 1'b0;
      aw_idx_q  <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      if (aw_fire) begin
        aw_held_q <= 1'b1;
        aw_map_q  <= (s_awaddr[ADDR_W-1:6] == '0);
        aw_idx_q  <= s_awaddr[5:2];
      end
      if (w_fire) begin
        w_held_q <= 1'b1;
        w_data_q <= s_wdata;
        w_strb_q <= s_wstrb;
      end
      if (commit) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
      end
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      ctrl_q    <= '0;
      counter_q <= '0;
      for (int i = 0; i < NumScratch; i++) scratch_q[i] <= '0;
    end else begin
      if (wr_hit_ctrl) ctrl_q <= merge(ctrl_q, w_data_q, w_strb_q);
      if (cnt_clr) begin
        counter_q <= '0;
      end else if (ctrl_q[0]) begin
        counter_q <= counter_q + 32'd1;
      end
      for (int i = 0; i < NumScratch; i++) begin
        if (commit && aw_map_q && (aw_idx_q == 4'(i + 4))) begin
          scratch_q[i] <= merge(scratch_q[i], w_data_q, w_strb_q);
        end
      end
    end
  end

  assign rd_idx = s_araddr[5:2];

  always_comb begin
    rd_word = '0;
    if (s_araddr[ADDR_W-1:6] == '0) begin
      case (rd_idx)
        4'd0:    rd_word = ID_VALUE;
        4'd1:    rd_word = ctrl_q;
        4'd2:    rd_word = counter_q;
        4'd3:    rd_word = '0;
        default: rd_word = scratch_q[rd_idx - 4'd4];
      endcase
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      rd_state_q <= StIdle;
      rdata_q    <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      rdata_q    <= rdata_d;
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    s_arready  = 1'b0;
    s_rvalid   = 1'b0;
    unique case (rd_state_q)
      StIdle: begin
        s_arready = 1'b1;
        if (s_arvalid) begin
          rdata_d    = rd_word;
          rd_state_d = StResp;
        end
      end
      StResp: begin
        s_rvalid = 1'b1;
        if (s_rready) rd_state_d = StIdle;
      end
      default: rd_state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_axil_cfg_slave.sv
// Bench for axil_cfg_slave: vector table plus hand-written timing sequences, reads checked
// through an expected-data queue.
module tb_axil_cfg_slave;

  logic        axis_clk = 1'b0;
  logic        axis_rst_n = 1'b0;
  logic        s_awvalid = 1'b0, s_wvalid = 1'b0, s_arvalid = 1'b0, s_rready = 1'b0;
  logic [31:0] s_awaddr = '0, s_araddr = '0, s_wdata = '0;
  logic [3:0]  s_wstrb = '0;
  logic        s_awready, s_wready, s_arready, s_rvalid;
  logic [31:0] s_rdata, ctrl_out;

  axil_cfg_slave dut (
    .axis_clk  (axis_clk),
    .axis_rst_n(axis_rst_n),
    .s_awvalid (s_awvalid),
    .s_awaddr  (s_awaddr),
    .s_awready (s_awready),
    .s_wvalid  (s_wvalid),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_wready  (s_wready),
    .s_arvalid (s_arvalid),
    .s_araddr  (s_araddr),
    .s_arready (s_arready),
    .s_rvalid  (s_rvalid),
    .s_rdata   (s_rdata),
    .s_rready  (s_rready),
    .ctrl_out  (ctrl_out)
  );

  always #5 axis_clk = ~axis_clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge axis_clk) cyc <= cyc + 1;

  typedef struct {
    bit          chk;
    logic [31:0] exp;
    string       name;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out got 0 expected 1", name);
  endtask

  task automatic sb_push(input bit chk, input logic [31:0] exp, input string name);
    sb_t e;
    e.chk = chk;
    e.exp = exp;
    e.name = name;
    sb.push_back(e);
  endtask

  // Called at a negedge where rvalid && rready: the handshake lands on the next posedge.
  task automatic sb_pop(output logic [31:0] data);
    sb_t e;
    data = s_rdata;
    if (sb.size() == 0) begin
      timeout("sb_underflow");
    end else begin
      e = sb.pop_front();
      if (e.chk) check(e.name, s_rdata, e.exp);
    end
  endtask

  // All bus tasks enter and leave on a negedge.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb);
    bit aw_ok, w_ok, a, w;
    int n;
    s_awvalid = 1'b1; s_awaddr = addr;
    s_wvalid = 1'b1; s_wdata = data; s_wstrb = strb;
    aw_ok = 1'b0; w_ok = 1'b0; n = 0;
    while (!(aw_ok && w_ok) && n < 50) begin
      a = s_awvalid && s_awready;
      w = s_wvalid && s_wready;
      @(posedge axis_clk);
      @(negedge axis_clk);
      if (a) begin s_awvalid = 1'b0; aw_ok = 1'b1; end
      if (w) begin s_wvalid = 1'b0; w_ok = 1'b1; end
      n++;
    end
    if (n >= 50) timeout("write_accept");
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    n = 0;
    while (!(s_awready && s_wready) && n < 10) begin
      @(negedge axis_clk);
      n++;
    end
    if (n >= 10) timeout("write_commit");
  endtask

  task automatic axi_read(input logic [31:0] addr, input bit chk, input logic [31:0] exp,
                          input string name, output logic [31:0] data, output int acc_cyc);
    bit acc;
    int n;
    data = '0;
    acc_cyc = 0;
    sb_push(chk, exp, name);
    s_arvalid = 1'b1; s_araddr = addr; s_rready = 1'b1;
    acc = 1'b0; n = 0;
    while (!acc && n < 50) begin
      acc = s_arready;
      @(posedge axis_clk);
      @(negedge axis_clk);
      n++;
    end
    s_arvalid = 1'b0;
    if (!acc) timeout("read_accept");
    acc_cyc = cyc;
    n = 0;
    while (!(s_rvalid && s_rready) && n < 20) begin
      @(negedge axis_clk);
      n++;
    end
    if (n >= 20) begin
      timeout("read_resp");
    end else begin
      sb_pop(data);
      @(posedge axis_clk);
      @(negedge axis_clk);
    end
  endtask

  vec_t tbl[$];

  initial begin
    logic [31:0] d, v1, v2;
    int a1, a2;

    tbl.push_back('{1'b1, 32'h00, 32'h0000_0000, 4'hF, 32'h0});
    tbl.push_back('{1'b0, 32'h00, 32'h0,         4'h0, 32'hA11C_0001});
    tbl.push_back('{1'b1, 32'h10, 32'h1122_3344, 4'hF, 32'h0});
    tbl.push_back('{1'b1, 32'h10, 32'hAABB_CCDD, 4'h5, 32'h0});
    tbl.push_back('{1'b0, 32'h10, 32'h0,         4'h0, 32'h11BB_33DD});
    tbl.push_back('{1'b1, 32'h3C, 32'h1234_5678, 4'hF, 32'h0});
    tbl.push_back('{1'b0, 32'h3C, 32'h0,         4'h0, 32'h1234_5678});
    tbl.push_back('{1'b1, 32'h14, 32'hFFFF_FFFF, 4'h0, 32'h0});
    tbl.push_back('{1'b0, 32'h14, 32'h0,         4'h0, 32'h0});
    tbl.push_back('{1'b1, 32'h40, 32'h0000_0005, 4'hF, 32'h0});
    tbl.push_back('{1'b0, 32'h40, 32'h0,         4'h0, 32'h0});
    tbl.push_back('{1'b1, 32'h50, 32'h0000_0005, 4'hF, 32'h0});
    tbl.push_back('{1'b0, 32'h10, 32'h0,         4'h0, 32'h11BB_33DD});
    tbl.push_back('{1'b0, 32'h0C, 32'h0,         4'h0, 32'h0});
    tbl.push_back('{1'b1, 32'h18, 32'hCAFE_F00D, 4'h8, 32'h0});
    tbl.push_back('{1'b0, 32'h18, 32'h0,         4'h0, 32'hCA00_0000});
    tbl.push_back('{1'b1, 32'h1F, 32'h0BAD_F00D, 4'hF, 32'h0});
    tbl.push_back('{1'b0, 32'h1D, 32'h0,         4'h0, 32'h0BAD_F00D});
    tbl.push_back('{1'b0, 32'h04, 32'h0,         4'h0, 32'h0});

    // Reset values while held in reset.
    #12;
    check("rst_awready", 32'(s_awready), 32'd1);
    check("rst_wready", 32'(s_wready), 32'd1);
    check("rst_arready", 32'(s_arready), 32'd1);
    check("rst_rvalid", 32'(s_rvalid), 32'd0);
    check("rst_rdata", s_rdata, 32'h0);
    check("rst_ctrl_out", ctrl_out, 32'h0);
    @(negedge axis_clk);
    axis_rst_n = 1'b1;
    @(negedge axis_clk);

    // ID read with one-cycle latency.
    sb_push(1'b1, 32'hA11C_0001, "id_read");
    s_arvalid = 1'b1; s_araddr = 32'h0; s_rready = 1'b1;
    check("id_arready", 32'(s_arready), 32'd1);
    @(posedge axis_clk);
    @(negedge axis_clk);
    s_arvalid = 1'b0;
    check("r_latency", 32'(s_rvalid), 32'd1);
    sb_pop(d);
    @(posedge axis_clk);
    @(negedge axis_clk);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].wr) axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb);
      else axi_read(tbl[i].addr, 1'b1, tbl[i].exp, $sformatf("vec%0d", i), d, a1);
    end

    // AW and W together: ctrl_out changes two edges after the valids are presented.
    s_awvalid = 1'b1; s_awaddr = 32'h04;
    s_wvalid = 1'b1; s_wdata = 32'h0000_00F1; s_wstrb = 4'h1;
    @(posedge axis_clk);
    @(negedge axis_clk);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    check("same_awready_low", 32'(s_awready), 32'd0);
    check("same_wready_low", 32'(s_wready), 32'd0);
    check("same_ctrl_before", ctrl_out, 32'h0);
    @(posedge axis_clk);
    @(negedge axis_clk);
    check("same_ctrl_after", ctrl_out, 32'h0000_00F1);
    check("same_awready_back", 32'(s_awready), 32'd1);
    check("same_wready_back", 32'(s_wready), 32'd1);

    // AW first, W three cycles later; an AR on the commit edge still sees the old word.
    s_awvalid = 1'b1; s_awaddr = 32'h10;
    @(posedge axis_clk);
    @(negedge axis_clk);
    s_awvalid = 1'b0;
    check("aw_held", 32'(s_awready), 32'd0);
    repeat (2) @(negedge axis_clk);
    check("aw_still_held", 32'(s_awready), 32'd0);
    s_wvalid = 1'b1; s_wdata = 32'hDEAD_BEEF; s_wstrb = 4'hF;
    @(posedge axis_clk);
    @(negedge axis_clk);
    s_wvalid = 1'b0;
    check("commit_wready_low", 32'(s_wready), 32'd0);
    sb_push(1'b1, 32'h11BB_33DD, "read_on_commit_edge");
    s_arvalid = 1'b1; s_araddr = 32'h10; s_rready = 1'b1;
    @(posedge axis_clk);
    @(negedge axis_clk);
    s_arvalid = 1'b0;
    check("post_commit_awready", 32'(s_awready), 32'd1);
    check("post_commit_wready", 32'(s_wready), 32'd1);
    if (s_rvalid) sb_pop(d);
    else timeout("commit_edge_rvalid");
    @(posedge axis_clk);
    @(negedge axis_clk);
    axi_read(32'h10, 1'b1, 32'hDEAD_BEEF, "late_w_read", d, a1);

    // Counter runs with CTRL[0]=1; successive reads differ by the AR edge spacing.
    axi_write(32'h04, 32'h1, 4'hF);
    repeat (20) @(negedge axis_clk);
    axi_read(32'h08, 1'b0, 32'h0, "cnt1", v1, a1);
    axi_read(32'h08, 1'b0, 32'h0, "cnt2", v2, a2);
    check("cnt_delta", v2 - v1, 32'(a2 - a1));
    check("read_rate", 32'(a2 - a1), 32'd2);
    check("cnt_running", 32'(v1 > 32'd20), 32'd1);

    // Clear beats increment: the read accepted right after the clear commit sees 0.
    axi_write(32'h0C, 32'h1, 4'h1);
    axi_read(32'h08, 1'b1, 32'h0, "cnt_after_clr", d, a1);

    // Wrap through 0xFFFF_FFFF.
    force dut.counter_q = 32'hFFFF_FFF0;
    repeat (2) @(negedge axis_clk);
    release dut.counter_q;
    axi_read(32'h08, 1'b0, 32'h0, "wrap1", v1, a1);
    repeat (30) @(negedge axis_clk);
    axi_read(32'h08, 1'b0, 32'h0, "wrap2", v2, a2);
    check("wrap_near_top", 32'(v1 >= 32'hFFFF_FFE0), 32'd1);
    check("wrap_small", 32'(v2 < 32'd64), 32'd1);
    check("wrap_delta", v2 - v1, 32'(a2 - a1));

    // CTRL[0]=0 freezes the counter.
    axi_write(32'h04, 32'h5A5A_0000, 4'hF);
    axi_read(32'h08, 1'b0, 32'h0, "stop1", v1, a1);
    repeat (10) @(negedge axis_clk);
    axi_read(32'h08, 1'b1, v1, "cnt_stopped", v2, a2);

    // R backpressure: response frozen, no new AR accepted.
    sb_push(1'b1, 32'h5A5A_0000, "bp_rdata_final");
    s_arvalid = 1'b1; s_araddr = 32'h04; s_rready = 1'b0;
    @(posedge axis_clk);
    @(negedge axis_clk);
    s_arvalid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("bp_rvalid%0d", i), 32'(s_rvalid), 32'd1);
      check($sformatf("bp_rdata%0d", i), s_rdata, 32'h5A5A_0000);
      check($sformatf("bp_arready%0d", i), 32'(s_arready), 32'd0);
      @(negedge axis_clk);
    end
    s_rready = 1'b1;
    sb_pop(d);
    @(posedge axis_clk);
    @(negedge axis_clk);
    check("bp_idle_arready", 32'(s_arready), 32'd1);
    check("bp_idle_rvalid", 32'(s_rvalid), 32'd0);

    // Reset mid-transaction: AW held and R pending.
    s_awvalid = 1'b1; s_awaddr = 32'h04;
    s_arvalid = 1'b1; s_araddr = 32'h3C; s_rready = 1'b0;
    @(posedge axis_clk);
    @(negedge axis_clk);
    s_awvalid = 1'b0; s_arvalid = 1'b0;
    check("pre_rst_rvalid", 32'(s_rvalid), 32'd1);
    check("pre_rst_awready", 32'(s_awready), 32'd0);
    #2 axis_rst_n = 1'b0;
    #1;
    check("mid_rst_rvalid", 32'(s_rvalid), 32'd0);
    check("mid_rst_rdata", s_rdata, 32'h0);
    check("mid_rst_awready", 32'(s_awready), 32'd1);
    check("mid_rst_arready", 32'(s_arready), 32'd1);
    check("mid_rst_ctrl", ctrl_out, 32'h0);
    @(negedge axis_clk);
    axis_rst_n = 1'b1;
    s_rready = 1'b1;
    s_wvalid = 1'b1; s_wdata = 32'hFFFF_FFFF; s_wstrb = 4'hF;
    @(posedge axis_clk);
    @(negedge axis_clk);
    s_wvalid = 1'b0;
    repeat (3) @(negedge axis_clk);
    check("no_commit_ctrl", ctrl_out, 32'h0);
    check("w_only_wready", 32'(s_wready), 32'd0);
    check("w_only_awready", 32'(s_awready), 32'd1);
    s_awvalid = 1'b1; s_awaddr = 32'h14;
    @(posedge axis_clk);
    @(negedge axis_clk);
    s_awvalid = 1'b0;
    @(posedge axis_clk);
    @(negedge axis_clk);
    axi_read(32'h14, 1'b1, 32'hFFFF_FFFF, "post_rst_s1", d, a1);
    axi_read(32'h04, 1'b1, 32'h0, "post_rst_ctrl", d, a1);
    axi_read(32'h10, 1'b1, 32'h0, "post_rst_s0", d, a1);
    axi_read(32'h08, 1'b1, 32'h0, "post_rst_cnt", d, a1);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axil_cfg_slave.md
# axil_cfg_slave

AXI-Lite configuration register slave on the downstream side of the AXIL_AXIS Axilite master port (m_aw*/m_w*/m_ar*/m_r*). It terminates the remote-initiated config transactions that arrive over AXI-stream and turn into Axilite accesses. It holds an ID word, a control register, a gated cycle counter and scratch registers. The channel set matches the master: AW, W, AR and R only, with no B channel.

## Interface
Parameters:
- ADDR_W, 32: address width; matches m_awaddr/m_araddr.
- ID_VALUE, 32'hA11C_0001: constant returned at offset 0x00.

Ports:
- axis_clk  in  1  sole clock.
- axis_rst_n  in  1  asynchronous, active-low reset.
- s_awvalid  in  1  write address valid.
- s_awaddr  in  ADDR_W  write byte address.
- s_awready  out  1  write address ready.
- s_wvalid  in  1  write data valid.
- s_wdata  in  32  write data.
- s_wstrb  in  4  byte enables; bit i qualifies wdata[8i+7:8i].
- s_wready  out  1  write data ready.
- s_arvalid  in  1  read address valid.
- s_araddr  in  ADDR_W  read byte address.
- s_arready  out  1  read address ready.
- s_rvalid  out  1  read data valid.
- s_rdata  out  32  read data.
- s_rready  in  1  read data ready.
- ctrl_out  out  32  live copy of CTRL.

## Operation
Address decode:
- Word index is addr[5:2]. addr[1:0] is ignored.
- If addr[ADDR_W-1:6] != 0, the access is unmapped: writes are dropped and reads return 0.

Register map:
- 0x00 ID: RO, ID_VALUE. Writes are ignored.
- 0x04 CTRL: RW, 32 bits, byte-strobed. Bit0 = counter enable.
- 0x08 COUNTER: RO, 32-bit.
  - Increments by 1 per cycle while CTRL[0]=1.
  - Wraps 0xFFFF_FFFF→0.
- 0x0C CNT_CLR: write-only pulse. A commit with wstrb[0]=1 and wdata[0]=1 zeroes COUNTER. Reads return 0.
- 0x10–0x3C SCRATCH0..11: RW, 32 bits, byte-strobed.

Write path:
- AW and W are accepted independently, each into its own one-entry holding register with a held flag.
- awready = !aw_held; wready = !w_held.
- Commit happens when both flags are set. The register update and the clearing of both flags occur on the same edge.
- Only bytes with wstrb=1 change. wstrb=0000 commits nothing but still completes the handshake.
- No response channel exists, so accepted writes cannot be rejected.

Read FSM, states IDLE and RESP:
- IDLE: arready=1, rvalid=0. On arvalid&&arready, rdata is loaded from the decoded register and the FSM goes to RESP.
- RESP: arready=0, rvalid=1, and rdata is held stable. On rvalid&&rready the FSM returns to IDLE.
- Read and write paths are independent and may be active in the same cycle.

Counter priority: CNT_CLR commit beats increment. The counter reads 0 on the cycle after the clear edge.

## Timing
- Reset values (asynchronous, all outputs):
  - awready=1, wready=1, arready=1.
  - rvalid=0, rdata=0.
  - ctrl_out=0, CTRL=0, COUNTER=0, all SCRATCH=0.
  - Both held flags clear; read FSM in IDLE.
- Write latency:
  - AW at edge N and W at edge M: the commit occurs at edge max(N,M)+1.
  - The new value is visible to ctrl_out and to reads from that edge.
  - AW and W in the same cycle (edge N): commit at N+1, and awready/wready return to 1 after N+1.
- Back-to-back writes: at most one write per 2 cycles, because ready is low during the commit cycle.
- Read latency:
  - AR accepted at edge N gives rvalid=1 after edge N.
  - rdata reflects register state before edge N, so a write committing at edge N is not seen.
  - COUNTER returns its pre-edge-N value.
- rvalid held with rready=0: rdata and state are frozen indefinitely, arready stays 0, and the counter keeps running.
- Next AR after an R handshake at edge K: arready=1 from after K, giving a sustained rate of 1 read per 2 cycles.
- Reset asserted mid-transaction: held AW/W is discarded with no commit, any pending rvalid drops to 0 immediately, and all registers take reset values.
- The counter stops on the edge after CTRL[0] is written to 0, holding its value.

## Test plan
- Reset then read 0x00 → rdata=0xA11C_0001 with rvalid one cycle after AR. Write 0x00=0 then read → still 0xA11C_0001.
- Ordering cases:
  - AW 0x04 with W 0x0000_00F1/wstrb 0001 in the same cycle → ctrl_out=0x0000_00F1 two edges later.
  - AW 0x10 first, W 0xDEAD_BEEF/1111 three cycles later → commit on the edge after W, and a read of 0x10 returns 0xDEAD_BEEF.
- Byte strobes: SCRATCH0=0x1122_3344, then write 0xAABB_CCDD with wstrb 0101 → read 0x10 returns 0x11BB_33DD.
- Counter:
  - Set CTRL=1, wait 20 cycles, read 0x08 twice back-to-back → second value minus first = cycles between the AR edges.
  - Write 0x0C=1 → the next read is small (<5).
  - Preload by running with CTRL=1 near wrap (force) → wraps 0xFFFF_FFFF→0.
- R backpressure: AR 0x04 with rready=0 for 10 cycles → rvalid stays 1, rdata is constant, arready=0; a handshake with rready=1 returns the FSM to IDLE.
- Unmapped and reset:
  - Write 0x40=0x5 → no register changes; a read of 0x40 returns 0.
  - Assert axis_rst_n=0 with AW held and rvalid=1 → all outputs take reset values immediately, and no commit occurs after release.
